// File: rtl/timer_controller.sv
// ============================================================================
// timer_controller
// ----------------------------------------------------------------------------
// Memory-mapped programmable countdown timer for the CPU I/O bus.
//
// A prescaler divides clk down to one tick every PRESCALE clocks. A 16-bit
// counter, loaded from RELOAD, decrements once per tick. When the counter
// expires, the ready flag is set (cleared by ack). In one-shot mode the
// timer stops in DONE and drops CTRL.enable. In periodic mode it reloads
// and keeps running.
//
// Register map (addr):
//   0 STATUS  RO  {13'b0, overrun, running, ready}
//                 Writing 1 to bit2 clears overrun. Other bits are ignored.
//   1 COUNT   RO  current counter value
//   2 RELOAD  RW  16-bit reload value, sampled at LOAD and at periodic reload
//   3 CTRL    RW  {13'b0, irq_en, periodic, enable}
//
// Ports:
//   clk    in   1   system clock; all state changes on posedge
//   rst_n  in   1   asynchronous reset, active-low
//   addr   in   2   register select
//   wr     in   1   single-cycle write strobe; wdata captured at posedge
//   wdata  in  16   write data
//   rdata  out 16   combinational read data selected by addr (no side effects)
//   ack    in   1   level; clears ready at the next posedge
//   irq    out  1   ready & CTRL.irq_en
//
// Parameters:
//   PRESCALE    clocks per tick (>= 1); 1 gives a tick on every clock
//   PRESCALE_W  prescaler width; must be able to hold PRESCALE-1
//
// Build option:
//   `define TIMER_CTRL_IRQ_EN  - implements CTRL bit2 (irq_en) and drives irq.
//   Left undefined, CTRL bit2 is not stored and reads 0, irq is held at 0,
//   and software polls STATUS.
// ============================================================================
module timer_controller #(
    parameter int PRESCALE   = 50_000_000,
    parameter int PRESCALE_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        ack,
    output logic        irq
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // Last prescaler value before wrapping. A tick is issued on this value.
    localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;

    logic [15:0]           r_count;
    logic [15:0]           w_count_next;
    logic [15:0]           r_reload;
    logic [15:0]           w_reload_next;
    logic [PRESCALE_W-1:0] r_prescaler;
    logic [PRESCALE_W-1:0] w_prescaler_next;
    logic                  r_enable;
    logic                  w_enable_next;
    logic                  r_periodic;
    logic                  w_periodic_next;
    logic                  r_ready;
    logic                  w_ready_next;
    logic                  r_overrun;
    logic                  w_overrun_next;

    // ------------------------------------------------------------------------
    // Decoded bus strobes and timer events
    // ------------------------------------------------------------------------
    logic w_ctrl_wr;
    logic w_reload_wr;
    logic w_status_wr;
    logic w_ctrl_enable;
    logic w_tick;
    logic w_expiry;
    logic w_running;
    logic w_irq_en;
    logic w_unused_wdata;

    assign w_ctrl_wr     = wr && (addr == ADDR_CTRL);
    assign w_reload_wr   = wr && (addr == ADDR_RELOAD);
    // Clearing overrun is the only effect a STATUS write can have.
    assign w_status_wr   = wr && (addr == ADDR_STATUS) && wdata[2];
    assign w_ctrl_enable = wdata[0];

    // The prescaler only advances in RUN, so the tick is qualified with it.
    assign w_tick    = (r_state == ST_RUN) && (r_prescaler == PS_LAST);

    // Expiry happens when a tick finds count at 1 or 0. This covers
    // RELOAD=0 without underflow. A CTRL write in the same clock takes
    // priority: the timer is stopped or restarted, and the tick is dropped.
    assign w_expiry  = w_tick && !w_ctrl_wr && (r_count <= 16'd1);

    assign w_running = (r_state == ST_LOAD) || (r_state == ST_RUN);

    // Upper write-data bits have no destination in any register.
    assign w_unused_wdata = ^wdata[15:3];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // A CTRL write decides the state from any state except IDLE.
    // In IDLE, only enable=1 has any effect.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl_wr && w_ctrl_enable) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_ctrl_wr) begin
                    w_state_next = w_ctrl_enable ? ST_LOAD : ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ctrl_wr) begin
                    w_state_next = w_ctrl_enable ? ST_LOAD : ST_IDLE;
                end else if (w_expiry && !r_periodic) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_ctrl_wr) begin
                    w_state_next = w_ctrl_enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_next     = r_count;
        w_prescaler_next = r_prescaler;
        w_reload_next    = r_reload;
        w_enable_next    = r_enable;
        w_periodic_next  = r_periodic;
        w_ready_next     = r_ready;
        w_overrun_next   = r_overrun;

        // Counter and prescaler
        case (r_state)
            ST_LOAD: begin
                // LOAD always takes the reload value and restarts the
                // prescaler, even if a CTRL write redirects the next state.
                w_count_next     = r_reload;
                w_prescaler_next = '0;
            end
            ST_RUN: begin
                w_prescaler_next = w_tick ? '0 : (r_prescaler + 1'b1);
                if (w_tick && !w_ctrl_wr) begin
                    if (w_expiry) begin
                        // Periodic mode uses the RELOAD value present in
                        // this clock, which may include a write made
                        // during this run.
                        w_count_next = r_periodic ? r_reload : 16'd0;
                    end else begin
                        w_count_next = r_count - 16'd1;
                    end
                end
            end
            default: begin
                // IDLE and DONE: counter and prescaler are frozen.
            end
        endcase

        // RELOAD register
        if (w_reload_wr) begin
            w_reload_next = wdata;
        end

        // CTRL register.
        // A one-shot expiry drops enable, so CTRL reads back as stopped.
        if (w_ctrl_wr) begin
            w_enable_next   = wdata[0];
            w_periodic_next = wdata[1];
        end else if (w_expiry && !r_periodic) begin
            w_enable_next = 1'b0;
        end

        // ready: an expiry beats a simultaneous ack.
        if (w_expiry) begin
            w_ready_next = 1'b1;
        end else if (ack) begin
            w_ready_next = 1'b0;
        end

        // overrun: an expiry found ready still set and not acked this clock.
        // A set in the same clock as a software clear wins, so the event is
        // not lost.
        if (w_status_wr) begin
            w_overrun_next = 1'b0;
        end
        if (w_expiry && r_ready && !ack) begin
            w_overrun_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_prescaler <= '0;
            r_reload    <= '0;
            r_enable    <= 1'b0;
            r_periodic  <= 1'b0;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_prescaler <= w_prescaler_next;
            r_reload    <= w_reload_next;
            r_enable    <= w_enable_next;
            r_periodic  <= w_periodic_next;
            r_ready     <= w_ready_next;
            r_overrun   <= w_overrun_next;
        end
    end

    // ------------------------------------------------------------------------
    // Optional interrupt enable
    // ------------------------------------------------------------------------
`ifdef TIMER_CTRL_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irq_en <= wdata[2];
        end
    end

    assign w_irq_en = r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    assign irq = r_ready & w_irq_en;

    // ------------------------------------------------------------------------
    // Read mux: purely combinational, so reads have no side effects.
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = 16'd0;
        case (addr)
            ADDR_STATUS: rdata = {13'd0, r_overrun, w_running, r_ready};
            ADDR_COUNT:  rdata = r_count;
            ADDR_RELOAD: rdata = r_reload;
            ADDR_CTRL:   rdata = {13'd0, w_irq_en, r_periodic, r_enable};
            default:     rdata = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_controller.sv
`timescale 1ns/1ps
// Self-checking bench for timer_controller with PRESCALE=4.
// Directed scenarios follow the timer's documented behaviour. A randomized
// bus sequence is then compared every clock with a time-based reference
// model. The model derives COUNT from the elapsed time since the last load,
// rather than stepping a counter.
module tb_timer_controller;
    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        wr = 1'b0;
    logic [15:0] wdata = 16'd0;
    logic        ack = 1'b0;
    logic [15:0] rdata;
    logic        irq;

    timer_controller #(.PRESCALE(PS), .PRESCALE_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ---------------- reference model ----------------
    // m_mode: 0 stopped, 1 loading, 2 counting, 3 finished (one-shot)
    int m_mode;
    int m_seg_start;   // clock index at which the counter was (re)loaded
    int m_seg_val;     // value loaded at m_seg_start
    int m_frozen;      // visible count while stopped or loading
    int m_reload;
    int cyc;           // number of clock edges since reset
    bit m_en, m_per, m_ie, m_ready, m_ovr;

    task automatic model_reset();
        m_mode = 0; m_seg_start = 0; m_seg_val = 0; m_frozen = 0; m_reload = 0;
        cyc = 0; m_en = 0; m_per = 0; m_ie = 0; m_ready = 0; m_ovr = 0;
    endtask

    function automatic int m_count();
        case (m_mode)
            0, 1:    return m_frozen;
            2:       return m_seg_val - (cyc - m_seg_start) / PS;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'd0;
        s[0] = m_ready;
        s[1] = (m_mode == 1) || (m_mode == 2);
        s[2] = m_ovr;
        return s;
    endfunction

    function automatic logic [15:0] m_ctrl();
        logic [15:0] c;
        c = 16'd0;
        c[0] = m_en;
        c[1] = m_per;
`ifdef TIMER_CTRL_IRQ_EN
        c[2] = m_ie;
`endif
        return c;
    endfunction

    function automatic logic m_irq();
`ifdef TIMER_CTRL_IRQ_EN
        return m_ready & m_ie;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model across one clock edge with the given bus inputs.
    task automatic model_edge(input bit w, input logic [1:0] a, input logic [15:0] d, input bit k);
        int prev, period;
        bit cw, sw, rw, expd;
        prev = m_count();
        cyc++;
        cw = w && (a == 2'd3);
        sw = w && (a == 2'd0) && d[2];
        rw = w && (a == 2'd2);
        period = (m_seg_val == 0) ? 1 : m_seg_val;
        // Ticks come every PS clocks after a load, and expiry occurs on tick
        // number max(loaded value, 1).
        expd = (m_mode == 2) && !cw && ((cyc - m_seg_start) == PS * period);
        if (sw) m_ovr = 0;
        if (expd && m_ready && !k) m_ovr = 1;
        if (expd) m_ready = 1;
        else if (k) m_ready = 0;
        case (m_mode)
            0: if (cw && d[0]) begin m_mode = 1; m_frozen = prev; end
            1: begin
                if (cw) begin m_mode = d[0] ? 1 : 0; m_frozen = m_reload; end
                else begin m_mode = 2; m_seg_start = cyc; m_seg_val = m_reload; end
            end
            2: begin
                if (cw) begin m_mode = d[0] ? 1 : 0; m_frozen = prev; end
                else if (expd) begin
                    if (m_per) begin m_seg_start = cyc; m_seg_val = m_reload; end
                    else m_mode = 3;
                end
            end
            default: if (cw) begin m_mode = d[0] ? 1 : 0; m_frozen = 0; end
        endcase
        if (cw) begin m_en = d[0]; m_per = d[1]; m_ie = d[2]; end
        else if (expd && !m_per) m_en = 0;
        if (rw) m_reload = int'(d);
    endtask

    // ---------------- bus helpers ----------------
    task automatic step(input bit w, input logic [1:0] a, input logic [15:0] d, input bit k);
        wr = w; addr = a; wdata = d; ack = k;
        @(posedge clk);
        model_edge(w, a, d, k);
        if (w) $display("t=%0t bus write addr=%0d data=%h ack=%0d", $time, a, d, k);
        #1;
        wr = 1'b0; ack = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            total++;
            if (v !== 16'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0000", a, v); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        $display("test_reset done");
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        int n;
        step(1, 2'd2, 16'd3, 0);
        step(1, 2'd3, 16'd1, 0);
        rd(0, v);
        total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL oneshot_running: got %h want 0002", v); end
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (v[0]) n = i;
        end
        total++;
        if (n != 12 + 1) begin bad++; $display("FAIL oneshot_latency: got %0d clks want 13", n); end
        rd(0, v);
        total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL oneshot_status: got %h want 0001", v); end
        rd(3, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_ctrl: got %h want 0000", v); end
        rd(1, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_count: got %h want 0000", v); end
        step(0, 2'd0, 16'd0, 1);
        rd(0, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_ack: got %h want 0000", v); end
        step(1, 2'd3, 16'd0, 0);
        $display("test_oneshot done");
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        int n;
        step(1, 2'd2, 16'd2, 0);
        step(1, 2'd3, 16'd3, 0);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (v[0]) n = i;
        end
        total++;
        if (n != 1 + 8) begin bad++; $display("FAIL periodic_first: got %0d clks want 9", n); end
        for (int i = 1; i <= 8; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (i == 7) begin
                total++;
                if (v !== 16'h0003) begin bad++; $display("FAIL periodic_pre_ovr: got %h want 0003", v); end
            end
        end
        total++;
        if (v !== 16'h0007) begin bad++; $display("FAIL periodic_overrun: got %h want 0007", v); end
        rd(1, v);
        total++;
        if (v !== 16'd2) begin bad++; $display("FAIL periodic_reload: got %h want 0002", v); end
        step(1, 2'd0, 16'h0004, 1);
        rd(0, v);
        total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL periodic_clear: got %h want 0002", v); end
        $display("test_periodic done");
    endtask

    task automatic test_ack_same_clk();
        logic [15:0] v;
        int n;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (v[0]) n = i;
        end
        total++;
        if (n == 0) begin bad++; $display("FAIL ack_wait: got timeout want expiry"); end
        repeat (7) step(0, 2'd0, 16'd0, 0);
        step(0, 2'd0, 16'd0, 1);
        rd(0, v);
        total++;
        if (v !== 16'h0003) begin bad++; $display("FAIL ack_same_clk: got %h want 0003", v); end
        step(0, 2'd0, 16'd0, 1);
        rd(0, v);
        total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL ack_clear: got %h want 0002", v); end
        step(1, 2'd3, 16'd0, 0);
        $display("test_ack_same_clk done");
    endtask

    task automatic test_reload_zero();
        logic [15:0] v;
        int n;
        step(1, 2'd2, 16'd0, 0);
        step(1, 2'd3, 16'd1, 0);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (v[0]) n = i;
        end
        total++;
        if (n != 1 + 4) begin bad++; $display("FAIL zero_latency: got %0d clks want 5", n); end
        rd(1, v);
        total++;
        if (v !== 16'd0) begin bad++; $display("FAIL zero_count: got %h want 0000", v); end
        step(1, 2'd3, 16'd0, 1);
        $display("test_reload_zero done");
    endtask

    task automatic test_stop_hold();
        logic [15:0] v;
        bit seen;
        step(1, 2'd2, 16'd9, 0);
        step(1, 2'd3, 16'd1, 0);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(1, v);
            if (v == 16'd5) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stop_reach5: got %h want 0005", v); end
        step(1, 2'd3, 16'd0, 0);
        rd(0, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL stop_status: got %h want 0000", v); end
        repeat (20) step(0, 2'd0, 16'd0, 0);
        rd(1, v);
        total++;
        if (v !== 16'd5) begin bad++; $display("FAIL stop_hold: got %h want 0005", v); end
        $display("test_stop_hold done");
    endtask

    task automatic test_irq_and_reset();
        logic [15:0] v;
        logic [15:0] want_ctrl;
        logic want_irq;
        int n;
`ifdef TIMER_CTRL_IRQ_EN
        want_ctrl = 16'h0007;
        want_irq  = 1'b1;
`else
        want_ctrl = 16'h0003;
        want_irq  = 1'b0;
`endif
        step(1, 2'd2, 16'd1, 0);
        step(1, 2'd3, 16'd7, 0);
        rd(3, v);
        total++;
        if (v !== want_ctrl) begin bad++; $display("FAIL irq_ctrl: got %h want %h", v, want_ctrl); end
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step(0, 2'd0, 16'd0, 0);
            rd(0, v);
            if (v[0]) n = i;
        end
        total++;
        if (irq !== want_irq) begin bad++; $display("FAIL irq_follow: got %b want %b", irq, want_irq); end
        step(0, 2'd0, 16'd0, 1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_ack: got %b want 0", irq); end
        step(0, 2'd0, 16'd0, 0);
        // Asynchronous reset in the middle of a run.
        #2 rst_n = 1'b0;
        model_reset();
        #0.5;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            total++;
            if (v !== 16'd0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0000", a, v); end
        end
        #1 rst_n = 1'b1;
        $display("test_irq_and_reset done");
    endtask

    task automatic test_random();
        logic [15:0] v, d;
        logic [1:0] a;
        bit w, k;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd2:    d = 16'($urandom_range(0, 5));
                2'd3:    d = 16'($urandom_range(0, 7));
                default: d = 16'($urandom);
            endcase
            k = ($urandom_range(0, 4) == 0);
            step(w, a, d, k);
            rd(0, v);
            total++;
            if (v !== m_status()) begin bad++; $display("FAIL rnd_status @%0d: got %h want %h", i, v, m_status()); end
            rd(1, v);
            total++;
            if (v !== 16'(m_count())) begin bad++; $display("FAIL rnd_count @%0d: got %h want %h", i, v, 16'(m_count())); end
            rd(2, v);
            total++;
            if (v !== 16'(m_reload)) begin bad++; $display("FAIL rnd_reload @%0d: got %h want %h", i, v, 16'(m_reload)); end
            rd(3, v);
            total++;
            if (v !== m_ctrl()) begin bad++; $display("FAIL rnd_ctrl @%0d: got %h want %h", i, v, m_ctrl()); end
            total++;
            if (irq !== m_irq()) begin bad++; $display("FAIL rnd_irq @%0d: got %b want %b", i, irq, m_irq()); end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_ack_same_clk();
        test_reload_zero();
        test_stop_hold();
        test_irq_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
